seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds NUM_DIGITS BCD digits plus decimal points in a frame-synchronised display buffer. It steps through the digits one at a time, sharing a single BCD_segment decoder across all of them, and drives one active-low anode per digit with a blanking gap between digits to suppress ghosting. It sits between the system's numeric datapath and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (≥2).
- REFRESH_DIV, 1000, clock cycles per digit slot (blank plus show).
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (1 ≤ BLANK_CYCLES < REFRESH_DIV).
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  scan enable; low forces display dark.
- load  input  1  one-cycle strobe that captures digits_in/dp_in into the pending buffer.
- digits_in  input  4*NUM_DIGITS  BCD digits; digit k = [4k+3:4k], digit 0 least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- an  output  NUM_DIGITS  anode enables, active-low, at most one low at a time.
- segment  output  8  active-low segment pattern; [6:0] from decoder, [7] = DP.
- frame_done  output  1  one-cycle pulse on the last show cycle of digit NUM_DIGITS-1.

## Operation
- FSM states: IDLE, BLANK, SHOW.
- IDLE: an all 1, segment 8'hFF, digit index 0. When enable = 1, go to BLANK for digit 0 and perform a commit.
- BLANK: an all 1, segment 8'hFF, lasting BLANK_CYCLES cycles. Then go to SHOW.
- SHOW: an[idx] = 0 and segment = decoded display digit idx, lasting REFRESH_DIV-BLANK_CYCLES cycles. Then advance idx, wrapping NUM_DIGITS-1 → 0, and go to BLANK.
- Commit: on entry to BLANK for digit 0, if pending_valid is set, the display buffer takes the pending buffer and pending_valid clears.
- Load during a commit cycle: the digits_in/dp_in on that cycle are committed directly (bypass) and pending_valid ends at 0.
- Load at any other time: overwrites pending and sets pending_valid. Last load before a commit wins.
- The display never changes mid-frame (no tearing).
- Digit values 10–15: segment[6:0] = 7'h7F (all off). DP is still honoured.
- enable = 0 in any state: next cycle IDLE, outputs dark, idx and slot counter cleared. Pending and display buffers are retained.
- Slot counter width: $clog2(REFRESH_DIV).

## Timing
- All outputs registered. an and segment change on the same edge; no combinational path from inputs to outputs.
- Reset values (asynchronous):
  - an = all 1, segment = 8'hFF, frame_done = 0.
  - state IDLE, idx 0.
  - display buffer = 0, dp = 0, pending_valid = 0.
- Latency: enable rising at edge t → BLANK at t+1 → first SHOW at t+1+BLANK_CYCLES.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles. frame_done pulses exactly once per frame.
- Load to visible: the data appears at the next frame start, at most NUM_DIGITS*REFRESH_DIV + BLANK_CYCLES cycles later.
- rst_n asserted mid-SHOW: outputs go dark immediately (asynchronously) and the loaded data is lost.

## Configuration
- SEG_SCAN_LZB_EN defined: leading-zero blanking. Starting from digit NUM_DIGITS-1 downward, each zero digit with all higher digits also zero shows segment[6:0] = 7'h7F. Digit 0 is never blanked. The DP of a blanked digit is still shown. Blanking is evaluated on the display buffer.
- SEG_SCAN_LZB_EN undefined: every digit is decoded as stored. No blanking logic is synthesised.

## Structure
- Shared package seg_scan_pkg:
  - state enum (IDLE/BLANK/SHOW).
  - SEG_OFF = 8'hFF and SEG_DIGIT_OFF = 7'h7F constants.
  - digit-width constant BCD_W = 4.
- One sub-module: a single instance of the existing BCD_segment decoder, fed by a mux on idx. Its output bit 7 is discarded and replaced by ~dp[idx].

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: rst_n=0 with enable=1 → an=4'b1111, segment=8'hFF, frame_done=0. Outputs hold while rst_n is low.
- Basic scan: load digits_in=16'h1234, dp_in=4'b0010, enable=1 → expected response:
  - 2 dark cycles, then an=1110 with digit 4 for 6 cycles.
  - then an=1101 with digit 3 and segment[7]=0 (DP lit).
  - then digit 2, then digit 1.
  - frame_done pulses every 32 cycles.
- Invalid code: digit 0 = 4'hC → segment=8'hFF while an=1110.
- Mid-frame load: 16'h1234 displayed; load 16'h5678 at frame cycle 10 → digits 1–3 of the current frame still show 3, 2, 1. The next frame shows 8, 7, 6, 5. Also check load on the commit cycle (bypass).
- Enable/reset abort: enable=0 mid-SHOW of digit 2 → an=1111 next cycle. Re-enable → restart at digit 0 after 2 blank cycles. Async rst_n pulse mid-SHOW → immediate dark.
- LZB: display 16'h0050:
  - with SEG_SCAN_LZB_EN: digits 3 and 2 show 7'h7F, digit 1 shows 5, digit 0 shows 0.
  - without SEG_SCAN_LZB_EN: all four digits decoded as stored.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [7:0]  SEG_OFF       = 8'hFF;
    localparam logic [6:0]  SEG_DIGIT_OFF = 7'h7F;
    localparam int unsigned BCD_W         = 4;

endpackage

// File: rtl/BCD_segment.sv
// BCD to active-low 7-segment decoder, bit order {dp,g,f,e,d,c,b,a}.
// Codes 10-15 decode to all segments off; dp bit is always off.
module BCD_segment
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Pure lookup, no state.
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0: seg = 8'hC0;
            4'd1: seg = 8'hF9;
            4'd2: seg = 8'hA4;
            4'd3: seg = 8'hB0;
            4'd4: seg = 8'h99;
            4'd5: seg = 8'h92;
            4'd6: seg = 8'h82;
            4'd7: seg = 8'hF8;
            4'd8: seg = 8'h80;
            4'd9: seg = 8'h90;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seven_seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    segment,
    output logic                          frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                           state, state_n;
    logic [IDX_W-1:0]                      idx, idx_n;
    logic [CNT_W-1:0]                      cnt, cnt_n;
    logic                                  commit;

    logic [NUM_DIGITS-1:0][BCD_W-1:0]      disp_digits, pend_digits;
    logic [NUM_DIGITS-1:0]                 disp_dp, pend_dp;
    logic                                  pend_valid;

    logic [BCD_W-1:0]                      cur_bcd;
    logic [6:0]                            dec_seg;
    logic                                  dec_dp_unused;
    logic [6:0]                            seg_lo;

    // Scan state, digit index and slot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; commit marks entry to BLANK of digit 0 (frame start).
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        commit  = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    idx_n   = '0;
                    cnt_n   = '0;
                    commit  = 1'b1;
                end
                BLANK: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BLANK_LAST)
                        state_n = SHOW;
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        if (idx == IDX_LAST) begin
                            idx_n  = '0;
                            commit = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Pending/display buffers; a load coinciding with a commit bypasses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_digits <= '0;
            disp_dp     <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
        end else if (commit) begin
            if (load) begin
                disp_digits <= digits_in;
                disp_dp     <= dp_in;
            end else if (pend_valid) begin
                disp_digits <= pend_digits;
                disp_dp     <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_digits <= digits_in;
            pend_dp     <= dp_in;
            pend_valid  <= 1'b1;
        end
    end

    // Outputs are registered from the next-state view so an/segment track state
    // without an extra cycle of lag; the shared decoder is muxed on idx_n.
    assign cur_bcd = disp_digits[idx_n];

    BCD_segment u_dec (
        .bcd (cur_bcd),
        .seg ({dec_dp_unused, dec_seg})
    );

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lzb;
    logic                  zero_run;

    // A digit blanks when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        lzb      = '0;
        zero_run = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
            zero_run = zero_run && (disp_digits[NUM_DIGITS - 1 - i] == '0);
            lzb[NUM_DIGITS - 1 - i] = zero_run;
        end
    end

    // Segment field of the shown digit, blanked when it is a leading zero.
    always_comb begin
        seg_lo = lzb[idx_n] ? SEG_DIGIT_OFF : dec_seg;
    end
`else
    // Segment field of the shown digit, decoded as stored.
    always_comb begin
        seg_lo = dec_seg;
    end
`endif

    // Registered anode, segment and frame_done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            segment    <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            if (state_n == SHOW) begin
                an      <= ~(NUM_DIGITS'(1) << idx_n);
                segment <= {~disp_dp[idx_n], seg_lo};
            end else begin
                an      <= '1;
                segment <= SEG_OFF;
            end
            frame_done <= (state_n == SHOW) && (idx_n == IDX_LAST) && (cnt_n == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Define SEG_SCAN_LZB_EN for both bench and RTL to check leading-zero blanking.
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [7:0]  segment;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .an         (an),
        .segment    (segment),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [7:0]  seg [4];
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl [5];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: a single frame-position counter m_t (-1 = idle).
    int          m_t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pv;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_t    = -1;
        m_disp = '0;
        m_dp   = '0;
        m_pv   = 1'b0;
    endtask

    // Advance the model by one clock edge and push the expected outputs.
    task automatic model_edge();
        exp_t       e;
        logic       commit;
        logic       blank;
        logic [6:0] lo;
        int         slot;
        if (!rst_n) begin
            model_reset();
        end else begin
            commit = 1'b0;
            if (!enable) begin
                m_t = -1;
            end else if (m_t < 0) begin
                m_t    = 0;
                commit = 1'b1;
            end else begin
                m_t    = (m_t + 1) % FR;
                commit = (m_t == 0);
            end
            if (commit) begin
                if (load) begin
                    m_disp = digits_in;
                    m_dp   = dp_in;
                end else if (m_pv) begin
                    m_disp = m_pend;
                    m_dp   = m_pdp;
                end
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = digits_in;
                m_pdp  = dp_in;
                m_pv   = 1'b1;
            end
        end
        e.an  = 4'hF;
        e.seg = 8'hFF;
        e.fd  = 1'b0;
        if (m_t >= 0 && (m_t % RD) >= BC) begin
            slot  = m_t / RD;
            lo    = dec7(m_disp[slot*4 +: 4]);
            blank = (slot > 0);
            for (int k = slot; k < ND; k++)
                if (m_disp[k*4 +: 4] != 4'h0) blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
            if (blank) lo = 7'h7F;
`endif
            e.an  = 4'hF ^ (4'h1 << slot);
            e.seg = {~m_dp[slot], lo};
        end
        e.fd = (m_t == FR - 1);
        exp_q.push_back(e);
    endtask

    // One clock: model at the rising edge, scoreboard compare at the falling edge.
    task automatic step();
        exp_t e;
        exp_t a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            a = {an, segment, frame_done};
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0d: an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                         m_t, a.an, a.seg, a.fd, e.an, e.seg, e.fd);
            end
        end
    endtask

    // Step at least once, until the model reaches frame position tgt (bounded).
    task automatic wait_t(input int tgt);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (m_t != tgt && guard < 200);
        if (m_t != tgt) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_t: frame position %0d not reached, at %0d", tgt, m_t);
        end
    endtask

    // Wait for a fresh frame and check the first show cycle of each digit against the table.
    task automatic check_frame(input int i);
        wait_t(1);
        for (int s = 0; s < ND; s++) begin
            wait_t(s * RD + BC);
            chk($sformatf("tbl%0d_an%0d", i, s), {12'h0, an}, {12'h0, 4'hF ^ (4'h1 << s)});
            chk($sformatf("tbl%0d_seg%0d", i, s), {8'h0, segment}, {8'h0, tbl[i].seg[s]});
        end
    endtask

    initial begin
        int c;
        tbl[0] = '{16'h1234, 4'b0010, '{8'h99, 8'h30, 8'hA4, 8'hF9}};
        tbl[1] = '{16'h567C, 4'b0000, '{8'hFF, 8'hF8, 8'h82, 8'h92}};
`ifdef SEG_SCAN_LZB_EN
        tbl[2] = '{16'h0050, 4'b0000, '{8'hC0, 8'h92, 8'hFF, 8'hFF}};
        tbl[4] = '{16'h0000, 4'b0100, '{8'hC0, 8'hFF, 8'h7F, 8'hFF}};
`else
        tbl[2] = '{16'h0050, 4'b0000, '{8'hC0, 8'h92, 8'hC0, 8'hC0}};
        tbl[4] = '{16'h0000, 4'b0100, '{8'hC0, 8'hC0, 8'h40, 8'hC0}};
`endif
        tbl[3] = '{16'hF890, 4'b1001, '{8'h40, 8'h90, 8'h80, 8'h7F}};

        rst_n     = 1'b0;
        enable    = 1'b1;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        m_pend    = '0;
        m_pdp     = '0;
        model_reset();

        // Reset held with enable high: outputs stay dark.
        repeat (3) step();
        chk("reset_an", {12'h0, an}, 16'h000F);
        chk("reset_seg", {8'h0, segment}, 16'h00FF);
        chk("reset_fd", {15'h0, frame_done}, 16'h0000);

        // Basic scan: load while disabled, then enable.
        rst_n  = 1'b1;
        enable = 1'b0;
        step();
        digits_in = tbl[0].digits;
        dp_in     = tbl[0].dp;
        load      = 1'b1;
        step();
        load   = 1'b0;
        enable = 1'b1;
        check_frame(0);

        // Frame period between frame_done pulses.
        c = 0;
        while (!frame_done && c < 100) begin
            step();
            c++;
        end
        c = 0;
        do begin
            step();
            c++;
        end while (!frame_done && c < 100);
        chk("frame_period", 16'(c), 16'(FR));

        // Table vectors loaded while scanning (invalid code, DP, blanking cases).
        for (int i = 1; i < 5; i++) begin
            digits_in = tbl[i].digits;
            dp_in     = tbl[i].dp;
            load      = 1'b1;
            step();
            load = 1'b0;
            check_frame(i);
        end

        // Mid-frame load: current frame keeps old digits, next frame shows new ones.
        digits_in = tbl[0].digits;
        dp_in     = tbl[0].dp;
        load      = 1'b1;
        step();
        load = 1'b0;
        check_frame(0);
        wait_t(9);
        digits_in = 16'h5678;
        dp_in     = 4'b0000;
        load      = 1'b1;
        step();
        load = 1'b0;
        wait_t(18);
        chk("midload_old_d2", {8'h0, segment}, 16'h00A4);
        wait_t(26);
        chk("midload_old_d3", {8'h0, segment}, 16'h00F9);
        wait_t(2);
        chk("midload_new_d0", {8'h0, segment}, 16'h0080);
        wait_t(10);
        chk("midload_new_d1", {8'h0, segment}, 16'h00F8);
        wait_t(18);
        chk("midload_new_d2", {8'h0, segment}, 16'h0082);
        wait_t(26);
        chk("midload_new_d3", {8'h0, segment}, 16'h0092);

        // Load on the commit cycle bypasses pending and clears the earlier pending load.
        wait_t(12);
        digits_in = 16'h1111;
        load      = 1'b1;
        step();
        load = 1'b0;
        wait_t(FR - 1);
        digits_in = 16'h2222;
        load      = 1'b1;
        step();
        load = 1'b0;
        wait_t(2);
        chk("bypass_frame1", {8'h0, segment}, 16'h00A4);
        wait_t(2);
        chk("bypass_frame2", {8'h0, segment}, 16'h00A4);

        // Enable drop mid-SHOW of digit 2, then restart at digit 0.
        wait_t(20);
        enable = 1'b0;
        step();
        chk("abort_an", {12'h0, an}, 16'h000F);
        chk("abort_seg", {8'h0, segment}, 16'h00FF);
        step();
        enable = 1'b1;
        step();
        chk("restart_blank0", {12'h0, an}, 16'h000F);
        step();
        chk("restart_blank1", {12'h0, an}, 16'h000F);
        step();
        chk("restart_an", {12'h0, an}, 16'h000E);
        chk("restart_seg", {8'h0, segment}, 16'h00A4);

        // Asynchronous reset mid-SHOW with a pending load: dark at once, data lost.
        wait_t(12);
        digits_in = 16'h9999;
        load      = 1'b1;
        step();
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an", {12'h0, an}, 16'h000F);
        chk("async_seg", {8'h0, segment}, 16'h00FF);
        chk("async_fd", {15'h0, frame_done}, 16'h0000);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        wait_t(2);
        chk("post_reset_d0", {8'h0, segment}, 16'h00C0);
        wait_t(26);
`ifdef SEG_SCAN_LZB_EN
        chk("post_reset_d3", {8'h0, segment}, 16'h00FF);
`else
        chk("post_reset_d3", {8'h0, segment}, 16'h00C0);
`endif
        wait_t(2);
        chk("post_reset_next_d0", {8'h0, segment}, 16'h00C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
